// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor front end: word width, NOP encoding,
// instruction field positions and the fetch FSM state type.
package proc_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  // Instruction word layout as decoded by ID
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 3;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instr} pairs; flush empties it and wins over push/pop.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DW-1:0]              head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so pointers wrap on natural overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding req/ack memory port, prefetch FIFO
// towards ID, with stall and branch redirect/flush.
module if_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] NOP_WORD   = proc_pkg::NOP_WORD
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  imem_req,
  output logic [15:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_data,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_target,
  output logic [15:0]           instruction,
  output logic [15:0]           pc_out,
  output logic                  instr_valid,
  output proc_pkg::fetch_state_e fsm_state
);
  import proc_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: imem_req=1 presents imem_addr and keeps it stable until a cycle with
  // imem_ack=1 completes the transfer; ack while req=0 carries no meaning.
  fetch_state_e    state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     stale_addr_q, stale_addr_d;
  logic [15:0]     last_pc_q;

  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count_after_push;

  assign instr_valid      = !empty;
  assign pop              = instr_valid && !stall && !branch_taken;
  assign count_after_push = count + CW'(1) - CW'(pop);
  assign push_entry       = '{pc: fetch_pc_q, instr: imem_data};
  assign fsm_state        = state_q;

  assign instruction = empty ? NOP_WORD  : head.instr;
  assign pc_out      = empty ? last_pc_q : head.pc;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    push         = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) fetch_pc_d = branch_target;
        else if (!full)   state_d    = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          // Without an ack the memory still owes us a word for the old address
          if (!imem_ack) begin
            stale_addr_d = fetch_pc_q;
            state_d      = DISCARD;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 16'd1;
          state_d    = (count_after_push < CW'(FIFO_DEPTH)) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = stale_addr_q;
        if (branch_taken) fetch_pc_d = branch_target;
        if (imem_ack)     state_d    = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
      last_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      if (!empty) last_pc_q <= head.pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (branch_taken),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus a wrap/async-reset sequence.
module tb_if_stage;
  import proc_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic        instr_valid;
  fetch_state_e fsm_state;

  logic        reset2_n = 1'b0;
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic        imem_ack2 = 1'b0;
  logic [15:0] imem_data2;
  logic        stall2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [15:0] target2 = 16'h0000;
  logic [15:0] instruction2;
  logic [15:0] pc_out2;
  logic        instr_valid2;
  fetch_state_e fsm_state2;

  // memory model: word at address A is 16'h2000 + A
  assign imem_data  = 16'h2000 + imem_addr;
  assign imem_data2 = 16'h2000 + imem_addr2;

  if_stage dut (
    .clock (clock), .reset_n (reset_n),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ack (imem_ack), .imem_data (imem_data),
    .stall (stall), .branch_taken (branch_taken), .branch_target (branch_target),
    .instruction (instruction), .pc_out (pc_out), .instr_valid (instr_valid),
    .fsm_state (fsm_state)
  );

  if_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clock (clock), .reset_n (reset2_n),
    .imem_req (imem_req2), .imem_addr (imem_addr2),
    .imem_ack (imem_ack2), .imem_data (imem_data2),
    .stall (stall2), .branch_taken (branch2), .branch_target (target2),
    .instruction (instruction2), .pc_out (pc_out2), .instr_valid (instr_valid2),
    .fsm_state (fsm_state2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ack;
    logic        br;
    logic [15:0] tgt;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic add(input logic rst, input logic st, input logic ack, input logic br,
                     input logic [15:0] tgt, input logic req, input logic [15:0] addr,
                     input logic valid, input logic [15:0] instr, input logic [15:0] pc);
    vec_t v;
    v.rst = rst; v.stall = st; v.ack = ack; v.br = br; v.tgt = tgt;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_instr = instr; v.exp_pc = pc;
    vecs.push_back(v);
  endtask

  // scoreboard compare
  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // driver: reset ends in the low phase with reset released
  task automatic do_reset();
    reset_n      = 1'b0;
    imem_ack     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_wrap(input int idx, input logic req, input logic [15:0] addr,
                            input logic valid, input logic [15:0] instr,
                            input logic [15:0] pc);
    chk("wrap_req",   idx, {15'd0, imem_req2},    {15'd0, req});
    chk("wrap_addr",  idx, imem_addr2,            addr);
    chk("wrap_valid", idx, {15'd0, instr_valid2}, {15'd0, valid});
    chk("wrap_instr", idx, instruction2,          instr);
    chk("wrap_pc",    idx, pc_out2,               pc);
  endtask

  initial begin
    // A: continuous ack, no stall
    add(1,0,1,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0002, 1,16'h2001,16'h0001);
    add(0,0,1,0,16'h0000, 1,16'h0003, 1,16'h2002,16'h0002);
    // B: stall for six cycles fills the FIFO, then drains and refetches
    add(1,1,1,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000);
    add(0,1,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,1,1,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,1,1,0,16'h0000, 0,16'h0002, 1,16'h2000,16'h0000);
    add(0,1,1,0,16'h0000, 0,16'h0002, 1,16'h2000,16'h0000);
    add(0,1,1,0,16'h0000, 0,16'h0002, 1,16'h2000,16'h0000);
    add(0,0,1,0,16'h0000, 0,16'h0002, 1,16'h2000,16'h0000);
    add(0,0,1,0,16'h0000, 0,16'h0002, 1,16'h2001,16'h0001);
    add(0,0,1,0,16'h0000, 1,16'h0002, 0,16'h0000,16'h0001);
    add(0,0,1,0,16'h0000, 1,16'h0003, 1,16'h2002,16'h0002);
    // C: ack after three req cycles, exactly one word buffered
    add(1,0,0,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,1,0,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,1,0,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,0,0,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,0,0,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000);
    // D: branch to 0x0040 while addr 5 is outstanding without ack
    add(1,0,1,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0002, 1,16'h2001,16'h0001);
    add(0,0,1,0,16'h0000, 1,16'h0003, 1,16'h2002,16'h0002);
    add(0,0,1,0,16'h0000, 1,16'h0004, 1,16'h2003,16'h0003);
    add(0,0,0,1,16'h0040, 1,16'h0005, 1,16'h2004,16'h0004);
    add(0,0,0,0,16'h0000, 1,16'h0005, 0,16'h0000,16'h0004);
    add(0,0,1,0,16'h0000, 1,16'h0005, 0,16'h0000,16'h0004);
    add(0,0,1,0,16'h0000, 1,16'h0040, 0,16'h0000,16'h0004);
    add(0,0,1,0,16'h0000, 1,16'h0041, 1,16'h2040,16'h0040);
    // E: branch to 0x0100 in the same cycle as ack
    add(1,0,1,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000);
    add(0,0,1,0,16'h0000, 1,16'h0001, 1,16'h2000,16'h0000);
    add(0,0,1,1,16'h0100, 1,16'h0002, 1,16'h2001,16'h0001);
    add(0,0,0,0,16'h0000, 1,16'h0100, 0,16'h0000,16'h0001);
    add(0,0,1,0,16'h0000, 1,16'h0100, 0,16'h0000,16'h0001);
    add(0,0,0,0,16'h0000, 1,16'h0101, 1,16'h2100,16'h0100);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else             @(negedge clock);
      stall         = vecs[i].stall;
      imem_ack      = vecs[i].ack;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      #1;
      chk("req",   i, {15'd0, imem_req},    {15'd0, vecs[i].exp_req});
      chk("addr",  i, imem_addr,            vecs[i].exp_addr);
      chk("valid", i, {15'd0, instr_valid}, {15'd0, vecs[i].exp_valid});
      chk("instr", i, instruction,          vecs[i].exp_instr);
      chk("pc",    i, pc_out,               vecs[i].exp_pc);
    end

    // F: RESET_PC=FFFF wraps to 0000; async reset mid-REQ
    @(negedge clock);
    reset2_n  = 1'b1;
    imem_ack2 = 1'b1;
    #1 check_wrap(0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);
    @(negedge clock);
    #1 check_wrap(1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);
    @(negedge clock);
    #1 check_wrap(2, 1'b1, 16'h0000, 1'b1, 16'h1FFF, 16'hFFFF);
    @(negedge clock);
    #1 check_wrap(3, 1'b1, 16'h0001, 1'b1, 16'h2000, 16'h0000);
    @(negedge clock);
    #1 check_wrap(4, 1'b1, 16'h0002, 1'b1, 16'h2001, 16'h0001);
    #1 reset2_n = 1'b0;
    #1 check_wrap(5, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);
    @(negedge clock);
    #1 check_wrap(6, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
